// File: rtl/fft_sample_loader.sv
`default_nettype none
// ============================================================================
// Module   : fft_sample_loader
// Brief    : Streams one frame of PCM samples into the FFT sample RAM as
//            {sample, 16'h0} words, in bit-reversed address order.
// Revision : 1.0
// ============================================================================
module fft_sample_loader #(
    parameter int ADDR_W      = 10,
    parameter int SAMPLE_W    = 16,
    parameter int BIT_REVERSE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [15:0]         frame_count,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_data,
    output logic [ADDR_W-1:0]   ram_address,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [3:0]          ram_byteenable,
    output logic [31:0]         ram_writedata,
    input  logic                ram_waitrequest
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [ADDR_W-1:0] C_LAST_IDX = '1;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_idx;
    logic              r_pend;
    logic              r_aborted;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic              r_done;
    logic [15:0]       r_frame_count;

    logic [ADDR_W-1:0] w_map;
    logic [15:0]       w_sext;
    logic              w_accept;
    logic              w_wr_done;
    logic              w_ready;

    generate
        if (BIT_REVERSE != 0) begin : g_bitrev
            for (genvar b = 0; b < ADDR_W; b++) begin : g_bit
                assign w_map[b] = r_idx[ADDR_W-1-b];
            end
        end else begin : g_linear
            assign w_map = r_idx;
        end
    endgenerate

    generate
        if (SAMPLE_W < 16) begin : g_sext_pad
            assign w_sext = {{(16-SAMPLE_W){s_data[SAMPLE_W-1]}}, s_data};
        end else begin : g_sext_full
            assign w_sext = s_data[15:0];
        end
    endgenerate

    // The holding register can take a new sample whenever it is empty or
    // its current write retires in this very cycle.
    assign w_ready   = (r_state == S_FILL) & (~r_pend | ~ram_waitrequest);
    assign w_accept  = s_valid & w_ready;
    assign w_wr_done = r_pend & ~ram_waitrequest;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_pend        <= 1'b0;
            r_aborted     <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
            r_done        <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_done <= 1'b0;

            if (w_accept) begin
                r_pend <= 1'b1;
                r_addr <= w_map;
                r_data <= {w_sext, 16'h0000};
            end else if (w_wr_done) begin
                r_pend <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_idx     <= '0;
                    r_aborted <= 1'b0;
                    if (start && !abort) begin
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_accept) begin
                        r_idx <= r_idx + 1'b1;
                    end
                    if (abort) begin
                        r_aborted <= 1'b1;
                        r_state   <= S_DRAIN;
                    end else if (w_accept && (r_idx == C_LAST_IDX)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        r_aborted <= 1'b1;
                    end
                    // An aborted frame still retires its stalled write, but is not counted.
                    if (!r_pend || w_wr_done) begin
                        r_state <= S_IDLE;
                        r_idx   <= '0;
                        if (!(r_aborted || abort)) begin
                            r_done        <= 1'b1;
                            r_frame_count <= r_frame_count + 16'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy           = (r_state != S_IDLE);
    assign done           = r_done;
    assign frame_count    = r_frame_count;
    assign s_ready        = w_ready;
    assign ram_address    = r_addr;
    assign ram_write      = r_pend;
    assign ram_chipselect = r_pend;
    assign ram_byteenable = {4{r_pend}};
    assign ram_writedata  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_fft_sample_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_sample_loader
// Brief    : Directed self-checking bench for fft_sample_loader.
// Revision : 1.0
// ============================================================================
module tb_fft_sample_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        s_valid;
    logic [15:0] s_data;
    logic        ram_waitrequest;

    logic        busy, done, s_ready;
    logic [15:0] frame_count;
    logic [9:0]  ram_address;
    logic        ram_chipselect, ram_write;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_writedata;

    logic        busy_l, done_l, s_ready_l;
    logic [15:0] frame_count_l;
    logic [9:0]  ram_address_l;
    logic        ram_chipselect_l, ram_write_l;
    logic [3:0]  ram_byteenable_l;
    logic [31:0] ram_writedata_l;

    int n_vec = 0;
    int n_err = 0;
    bit rand_wait = 1'b0;

    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];
    bit          seen  [1024];
    int          wr_cnt, dup_cnt, stall_viol, cs_viol, done_cnt;
    bit          prev_stall;
    logic [9:0]  prev_addr;
    logic [31:0] prev_data;

    always #5 clk = ~clk;

    fft_sample_loader #(.ADDR_W(10), .SAMPLE_W(16), .BIT_REVERSE(1)) u_dut_rev (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .busy(busy), .done(done), .frame_count(frame_count),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .ram_address(ram_address), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_byteenable(ram_byteenable),
        .ram_writedata(ram_writedata), .ram_waitrequest(ram_waitrequest)
    );

    fft_sample_loader #(.ADDR_W(10), .SAMPLE_W(16), .BIT_REVERSE(0)) u_dut_lin (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .busy(busy_l), .done(done_l), .frame_count(frame_count_l),
        .s_valid(s_valid), .s_ready(s_ready_l), .s_data(s_data),
        .ram_address(ram_address_l), .ram_chipselect(ram_chipselect_l),
        .ram_write(ram_write_l), .ram_byteenable(ram_byteenable_l),
        .ram_writedata(ram_writedata_l), .ram_waitrequest(ram_waitrequest)
    );

    function automatic logic [9:0] brev(input logic [9:0] x);
        logic [9:0] r;
        for (int b = 0; b < 10; b++) r[b] = x[9-b];
        return r;
    endfunction

    // RAM model and Avalon protocol observer; inputs change just after posedge.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (ram_write !== 1'b1 || ram_address !== prev_addr ||
                               ram_writedata !== prev_data || ram_byteenable !== 4'hF))
                stall_viol <= stall_viol + 1;
            if (ram_chipselect !== ram_write) cs_viol <= cs_viol + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (ram_write && !ram_waitrequest) begin
                if (seen[ram_address]) dup_cnt <= dup_cnt + 1;
                seen[ram_address]  <= 1'b1;
                mem_a[ram_address] <= ram_writedata;
                wr_cnt             <= wr_cnt + 1;
            end
            if (ram_write_l && !ram_waitrequest) mem_b[ram_address_l] <= ram_writedata_l;
            prev_stall <= ram_write & ram_waitrequest;
            prev_addr  <= ram_address;
            prev_data  <= ram_writedata;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_wait) ram_waitrequest = 1'($urandom_range(0, 1));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_cnt = 0; dup_cnt = 0; stall_viol = 0; cs_viol = 0; done_cnt = 0;
        for (int k = 0; k < 1024; k++) seen[k] = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one sample; returns one cycle after it is accepted.
    task automatic send(input logic [15:0] d);
        bit ok;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = s_ready;
            tick();
        end
        if (!ok) check("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input int bound);
        bit seen_done;
        seen_done = 1'b0;
        for (int t = 0; t < bound && !seen_done; t++) begin
            @(negedge clk);
            seen_done = done;
        end
        check("done_seen", 32'(seen_done), 32'd1);
        tick();
    endtask

    task automatic finish_frame(input logic [15:0] fc_exp);
        s_valid = 1'b0;
        @(negedge clk);
        check("last_write_pending", {29'd0, busy, done, ram_write}, {29'd0, 3'b101});
        @(negedge clk);
        check("done_cycle", {30'd0, busy, done}, {30'd0, 2'b01});
        check("frame_count", 32'(frame_count), 32'(fc_exp));
        tick();
    endtask

    initial begin
        int bad;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        s_valid = 1'b0; s_data = '0; ram_waitrequest = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {29'd0, busy, done, s_ready}, 32'd0);
        check("reset_ram", {ram_write, ram_chipselect, ram_byteenable, 16'(ram_address)}, 32'd0);
        check("reset_data", ram_writedata, 32'd0);
        check("reset_fc", 32'(frame_count), 32'd0);
        tick();
        reset = 1'b0;

        // start+abort together in IDLE, with a sample offered
        s_valid = 1'b1; s_data = 16'h0007; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle", {30'd0, busy, s_ready}, 32'd0);
        tick();
        s_valid = 1'b0;

        // Frame 1: bit-reversed ramp
        clear_mon();
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < 1024; i++) begin
            send(16'(i));
            if (i == 0) check("first_write", {ram_write, 21'd0, ram_address}, {1'b1, 31'd0});
            if (i == 1) check("addr_i1", 32'(ram_address), 32'd512);
            if (i == 1) check("data_i1", ram_writedata, 32'h0001_0000);
            if (i == 3) check("addr_i3", 32'(ram_address), 32'd768);
            if (i == 3) check("addr_lin_i3", 32'(ram_address_l), 32'd3);
        end
        finish_frame(16'd1);
        check("f1_mem512", mem_a[512], 32'h0001_0000);
        check("f1_mem768", mem_a[768], 32'h0003_0000);
        check("f1_mem1023", mem_a[1023], 32'h03FF_0000);
        check("f1_wr_cnt", 32'(wr_cnt), 32'd1024);
        bad = 0;
        for (int k = 0; k < 1024; k++)
            if (mem_a[k] !== {6'd0, brev(10'(k)), 16'h0}) bad++;
        check("f1_mem_all", 32'(bad), 32'd0);

        // Frame 2: negative sample at index 5
        pulse_start();
        for (int i = 0; i < 1024; i++) send((i == 5) ? 16'h8001 : 16'(i));
        finish_frame(16'd2);
        check("lin_mem5", mem_b[5], 32'h8001_0000);
        check("lin_mem6", mem_b[6], 32'h0006_0000);
        check("rev_mem640", mem_a[640], 32'h8001_0000);

        // Reset during a stalled write of frame 3
        pulse_start();
        for (int i = 0; i < 50; i++) send(16'(i));
        s_valid = 1'b0; ram_waitrequest = 1'b1; reset = 1'b1;
        @(negedge clk);
        check("pre_reset_stall", 32'(ram_write), 32'd1);
        tick();
        reset = 1'b0; ram_waitrequest = 1'b0;
        @(negedge clk);
        check("post_reset_write", {28'd0, ram_write, busy, s_ready, done}, 32'd0);
        check("post_reset_fc", 32'(frame_count), 32'd0);
        tick();

        // Frame with random stalls and valid gaps
        clear_mon();
        rand_wait = 1'b1;
        pulse_start();
        for (int i = 0; i < 1024; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                tick();
            end
            send(16'(i) ^ 16'hA5A5);
        end
        s_valid = 1'b0;
        wait_done(200);
        rand_wait = 1'b0;
        ram_waitrequest = 1'b0;
        tick();
        check("rnd_wr_cnt", 32'(wr_cnt), 32'd1024);
        check("rnd_dup", 32'(dup_cnt), 32'd0);
        check("rnd_stall_stable", 32'(stall_viol), 32'd0);
        check("rnd_cs_eq_write", 32'(cs_viol), 32'd0);
        check("rnd_done_cnt", 32'(done_cnt), 32'd1);
        check("rnd_fc", 32'(frame_count), 32'd1);
        bad = 0;
        for (int k = 0; k < 1024; k++)
            if (mem_a[k] !== {16'(brev(10'(k))) ^ 16'hA5A5, 16'h0}) bad++;
        check("rnd_mem_all", 32'(bad), 32'd0);

        // Abort after 300 samples with the last write stalled
        clear_mon();
        pulse_start();
        for (int i = 0; i < 300; i++) send(16'(i));
        s_valid = 1'b0; ram_waitrequest = 1'b1; abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_sready", {29'd0, s_ready, busy, ram_write}, 32'b011);
        check("abort_hold_addr", 32'(ram_address), 32'(brev(10'd299)));
        tick();
        tick();
        ram_waitrequest = 1'b0;
        @(negedge clk);
        check("abort_stall_alive", 32'(ram_write), 32'd1);
        tick();
        @(negedge clk);
        check("abort_idle", {29'd0, busy, done, ram_write}, 32'd0);
        check("abort_wr_cnt", 32'(wr_cnt), 32'd300);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_fc", 32'(frame_count), 32'd1);
        tick();

        // Restart after abort: first sample lands at address 0
        clear_mon();
        pulse_start();
        send(16'h1234);
        s_valid = 1'b0;
        check("restart_addr", {ram_write, 21'd0, ram_address}, {1'b1, 31'd0});
        check("restart_data", ram_writedata, 32'h1234_0000);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        @(negedge clk);
        check("restart_abort_idle", {30'd0, busy, done}, 32'd0);
        tick();

        // start pulsed in FILL is ignored
        clear_mon();
        pulse_start();
        for (int i = 0; i < 1024; i++) begin
            start = (i == 10);
            send(16'(i));
            start = 1'b0;
            if (i == 1022) check("fill_start_busy", {30'd0, busy, done}, 32'b10);
        end
        finish_frame(16'd2);
        check("fill_start_wr_cnt", 32'(wr_cnt), 32'd1024);
        check("fill_start_done_cnt", 32'(done_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
